// File: rtl/pkt_loader.sv
// Ingress packet loader: packs a byte stream little-endian into 32-bit words, writes them
// after a length header slot, then writes the length at BASE_ADDR and hands off via start_o.
module pkt_loader #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
   parameter int unsigned       MAX_BYTES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid_i,
   input  logic [7:0]        s_data_i,
   input  logic              s_last_i,
   output logic              s_ready_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_width_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              start_o,
   input  logic              ready_i,
   output logic              busy_o,
   output logic              overflow_o
);

   localparam int unsigned CNT_W = $clog2(MAX_BYTES) + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_RECV   = 3'd1;
   localparam logic [2:0] ST_WR_PAY = 3'd2;
   localparam logic [2:0] ST_WR_LEN = 3'd3;
   localparam logic [2:0] ST_START  = 3'd4;

   logic [2:0]        state_q,     state_d;
   logic [CNT_W-1:0]  byte_cnt_q,  byte_cnt_d;
   logic [CNT_W-1:0]  word_idx_q,  word_idx_d;
   logic [DATA_W-1:0] pack_q,      pack_d;
   logic              last_q,      last_d;
   logic              ovf_q,       ovf_d;
   logic              mem_ce_q,    mem_ce_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [3:0]        mem_width_q, mem_width_d;
   logic [DATA_W-1:0] mem_data_q,  mem_data_d;

   logic              ready_s;
   logic              accept_s;
   logic [1:0]        lane_s;
   logic [DATA_W-1:0] new_pack_s;
   logic [ADDR_W-1:0] pay_addr_s;
   logic [DATA_W-1:0] len_data_s;

   assign ready_s    = (state_q == ST_IDLE) || (state_q == ST_RECV);
   assign s_ready_o  = ready_s & rst;
   assign accept_s   = s_valid_i & ready_s;
   assign lane_s     = byte_cnt_q[1:0];
   assign new_pack_s = pack_q | (DATA_W'(s_data_i) << {lane_s, 3'b000});
   assign pay_addr_s = BASE_ADDR + ADDR_W'(32'd4) + (ADDR_W'(word_idx_q) << 2);
   assign len_data_s = DATA_W'(byte_cnt_q);

   assign mem_ce_o    = mem_ce_q;
   assign mem_we_o    = mem_ce_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_width_o = mem_width_q;
   assign mem_data_o  = mem_data_q;
   assign start_o     = (state_q == ST_START);
   assign busy_o      = (state_q != ST_IDLE);
   assign overflow_o  = ovf_q;

   // Next-state logic; memory write fields are loaded on the edge that enters a write state
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      word_idx_d  = word_idx_q;
      pack_d      = pack_q;
      last_d      = last_q;
      ovf_d       = ovf_q;
      mem_ce_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_width_d = 4'd0;
      mem_data_d  = mem_data_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               ovf_d      = 1'b0;
               byte_cnt_d = CNT_W'(1);
               word_idx_d = '0;
               pack_d     = DATA_W'(s_data_i);
               last_d     = s_last_i;
               if (s_last_i) begin
                  state_d     = ST_WR_PAY;
                  mem_ce_d    = 1'b1;
                  mem_addr_d  = BASE_ADDR + ADDR_W'(32'd4);
                  mem_width_d = 4'd1;
                  mem_data_d  = DATA_W'(s_data_i);
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (!accept_s) begin
               state_d = ST_RECV;
            end else if (byte_cnt_q == MAX_CNT) begin
               // Saturated: byte is dropped, but a last flag still closes the packet
               ovf_d = 1'b1;
               if (s_last_i) begin
                  last_d = 1'b1;
                  if (lane_s != 2'd0) begin
                     state_d     = ST_WR_PAY;
                     mem_ce_d    = 1'b1;
                     mem_addr_d  = pay_addr_s;
                     mem_width_d = {2'b00, lane_s};
                     mem_data_d  = pack_q;
                  end else begin
                     state_d     = ST_WR_LEN;
                     mem_ce_d    = 1'b1;
                     mem_addr_d  = BASE_ADDR;
                     mem_width_d = 4'd4;
                     mem_data_d  = len_data_s;
                  end
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               pack_d     = new_pack_s;
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if ((lane_s == 2'd3) || s_last_i) begin
                  last_d      = s_last_i;
                  state_d     = ST_WR_PAY;
                  mem_ce_d    = 1'b1;
                  mem_addr_d  = pay_addr_s;
                  mem_width_d = {2'b00, lane_s} + 4'd1;
                  mem_data_d  = new_pack_s;
               end else begin
                  state_d = ST_RECV;
               end
            end
         end
         ST_WR_PAY: begin
            word_idx_d = word_idx_q + CNT_W'(1);
            pack_d     = '0;
            if (last_q) begin
               state_d     = ST_WR_LEN;
               mem_ce_d    = 1'b1;
               mem_addr_d  = BASE_ADDR;
               mem_width_d = 4'd4;
               mem_data_d  = len_data_s;
            end else begin
               state_d = ST_RECV;
            end
         end
         ST_WR_LEN: begin
            state_d = ST_START;
         end
         ST_START: begin
            if (ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_START;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered memory-port update
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         pack_q      <= '0;
         last_q      <= 1'b0;
         ovf_q       <= 1'b0;
         mem_ce_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_width_q <= 4'd0;
         mem_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         word_idx_q  <= word_idx_d;
         pack_q      <= pack_d;
         last_q      <= last_d;
         ovf_q       <= ovf_d;
         mem_ce_q    <= mem_ce_d;
         mem_addr_q  <= mem_addr_d;
         mem_width_q <= mem_width_d;
         mem_data_q  <= mem_data_d;
      end
   end

endmodule

// File: tb/tb_pkt_loader.sv
// Scoreboard bench for pkt_loader: expected memory writes are queued as packets are driven
// and compared against each observed write.
module tb_pkt_loader;

   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid_i, s_last_i, ready_i;
   logic [7:0]  s_data_i;
   logic        s_ready_o, mem_ce_o, mem_we_o, start_o, busy_o, overflow_o;
   logic [31:0] mem_addr_o, mem_data_o;
   logic [3:0]  mem_width_o;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  width;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] pkt_buf [0:15];
   int         lat;

   pkt_loader #(.ADDR_W(32), .DATA_W(32), .BASE_ADDR(32'h0000_0000), .MAX_BYTES(MAXB)) dut (
      .clk(clk), .rst(rst),
      .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
      .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_width_o(mem_width_o), .mem_data_o(mem_data_o),
      .start_o(start_o), .ready_i(ready_i), .busy_o(busy_o), .overflow_o(overflow_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every memory write is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (rst && mem_ce_o) begin
         check_eq("we", mem_we_o, 1);
         if (exp_q.size() == 0) begin
            check_eq("unexp_wr", exp_q.size(), 1);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check_eq("wr_addr", mem_addr_o, e.addr);
            check_eq("wr_width", mem_width_o, e.width);
            check_eq("wr_data", mem_data_o, e.data);
         end
      end
   end

   task automatic push_wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
      wr_t e;
      e.addr = a; e.width = w; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_pkt_exp(input int n);
      int eff, wd;
      logic [31:0] d;
      eff = (n < MAXB) ? n : MAXB;
      for (int w = 0; w * 4 < eff; w++) begin
         wd = ((eff - 4 * w) < 4) ? (eff - 4 * w) : 4;
         d = 32'd0;
         for (int k = 0; k < wd; k++) d[8*k +: 8] = pkt_buf[4*w + k];
         push_wr(32'(4 + 4 * w), 4'(wd), d);
      end
      push_wr(32'd0, 4'd4, 32'(eff));
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      logic done;
      done = 1'b0;
      @(negedge clk);
      s_valid_i = 1'b1; s_data_i = d; s_last_i = last;
      for (int i = 0; i < 50; i++) begin
         if (s_ready_o) begin
            @(posedge clk);
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("accepted", done, 1);
   endtask

   task automatic wait_start(output int l);
      l = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s_valid_i = 1'b0; s_last_i = 1'b0;
         l++;
         if (start_o) break;
      end
      check_eq("start_seen", start_o, 1);
      check_eq("sb_empty", exp_q.size(), 0);
   endtask

   task automatic send_pkt(input int n, output int l);
      push_pkt_exp(n);
      for (int i = 0; i < n; i++) send_byte(pkt_buf[i], (i == n - 1));
      wait_start(l);
   endtask

   task automatic release_ready();
      @(negedge clk);
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      check_eq("idle_after_rdy", {start_o, busy_o, s_ready_o}, 3'b001);
   endtask

   initial begin
      rst = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0; s_data_i = 8'd0; ready_i = 1'b0;
      #3;
      check_eq("rst_ctl", {s_ready_o, mem_ce_o, mem_we_o, mem_width_o, start_o, busy_o, overflow_o}, 0);
      check_eq("rst_addr", mem_addr_o, 0);
      check_eq("rst_data", mem_data_o, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("idle_ready", {s_ready_o, busy_o}, 2'b10);

      for (int i = 0; i < 8; i++) pkt_buf[i] = 8'(i + 1);
      send_pkt(8, lat);
      check_eq("lat8", lat, 3);
      release_ready();

      pkt_buf[0] = 8'hAA; pkt_buf[1] = 8'hBB; pkt_buf[2] = 8'hCC;
      pkt_buf[3] = 8'hDD; pkt_buf[4] = 8'hEE;
      send_pkt(5, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("hold", {start_o, busy_o, s_ready_o}, 3'b110);
      end
      release_ready();

      pkt_buf[0] = 8'h5A;
      send_pkt(1, lat);
      check_eq("lat1", lat, 3);
      release_ready();

      for (int i = 0; i < 12; i++) pkt_buf[i] = 8'(8'h21 + i);
      send_pkt(12, lat);
      check_eq("lat_ovf", lat, 2);
      check_eq("ovf_set", overflow_o, 1);
      release_ready();
      check_eq("ovf_sticky", overflow_o, 1);

      // Reset while the second word is being packed
      push_wr(32'd4, 4'd4, 32'h3433_3231);
      send_byte(8'h31, 1'b0);
      #1;
      check_eq("ovf_clr", overflow_o, 0);
      for (int i = 1; i < 6; i++) send_byte(8'(8'h31 + i), 1'b0);
      @(negedge clk);
      rst = 1'b0;
      s_valid_i = 1'b0;
      #1;
      check_eq("mid_rst_ctl", {s_ready_o, mem_ce_o, mem_we_o, mem_width_o, start_o, busy_o, overflow_o}, 0);
      check_eq("mid_rst_addr", mem_addr_o, 0);
      check_eq("mid_rst_data", mem_data_o, 0);
      check_eq("mid_rst_sb", exp_q.size(), 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 4; i++) pkt_buf[i] = 8'(8'h41 + i);
      send_pkt(4, lat);
      release_ready();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
